macrow4_seq: RTL and testbench
==============================

Name: macrow4_seq

Overview:
Sequencer for the macrow4 FP16 multiply-accumulate row. On a start command it fetches 4 weights from a synchronous-read scratch memory and loads them with one-hot enW strobes. It then streams 4*nvec X elements with enX. It collects one result per 4-element vector from valid_o/Y_o, forwards each result with its vector index, and signals done.

Parameters:
ADDR_W, 8, scratch memory address width; addresses wrap modulo 2^ADDR_W
CNT_W, 8, width of the vector count and result index
TIMEOUT, 64, drain watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
start_i  in  1  command pulse; sampled only in IDLE
w_base_i  in  ADDR_W  address of weight 0; weights 1..3 follow
x_base_i  in  ADDR_W  address of first X element; elements are contiguous
nvec_i  in  CNT_W  number of 4-element X vectors; 0 is legal
busy_o  out  1  high while state != IDLE
done_o  out  1  one-cycle pulse in DONE
err_o  out  1  watchdog error, sticky until next accepted start
mem_rd_o  out  1  memory read strobe
mem_addr_o  out  ADDR_W  memory read address
mem_rdata_i  in  16  read data, valid the cycle after mem_rd_o
enW_o  out  4  one-hot weight-load enable to macrow4 enW
W_o  out  16  weight data to macrow4 W_i
enX_o  out  1  X-valid to macrow4 enX
X_o  out  16  X data to macrow4 X_i
mac_valid_i  in  1  from macrow4 valid_o
mac_y_i  in  16  from macrow4 Y_o
y_valid_o  out  1  forwarded result strobe
y_o  out  16  forwarded result
y_idx_o  out  CNT_W  vector index of y_o

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs and internal counters clear to 0.
- All outputs are registered.
- FSM states: IDLE, LOADW, STREAMX, DRAIN, DONE.
- IDLE:
  - start_i with nvec_i==0 -> DONE. No memory reads, no enW/enX.
  - start_i with nvec_i!=0 -> LOADW. Latch the bases and nvec_i; clear err_o and the result count.
  - Call the cycle in which start_i is sampled t0.
- LOADW: cycles t1..t4.
  - mem_rd_o=1 each cycle; mem_addr_o = w_base+0..3.
  - Then go to STREAMX.
- STREAMX: cycles t5..t(4+4n).
  - mem_rd_o=1 each cycle; mem_addr_o = x_base+k for k=0..4n-1.
  - Go to DRAIN after the last read.
- Memory-to-macrow4 alignment:
  - A read issued in cycle c returns data in c+1.
  - In c+2 the block drives exactly one of:
    - enW_o one-hot (0001,0010,0100,1000 for weights 0..3) with W_o = data
    - enX_o=1 with X_o = data
  - So enW_o is active t3..t6 and enX_o is active t7..t(6+4n), back to back.
  - enW_o/enX_o are 0 in all other cycles. W_o/X_o hold their last value.
- Results, while busy_o=1:
  - Each mac_valid_i cycle: y_valid_o=1 next cycle, y_o = mac_y_i, y_idx_o = result count. The count then increments.
  - y_valid_o is a single-cycle pulse.
  - mac_valid_i in IDLE or DONE is ignored.
  - Valids beyond nvec are ignored, with no forwarding.
- DRAIN -> DONE when the last enX_o has been issued and result count == nvec. There is no dependency on macrow4's internal latency.
- DONE: done_o=1 for one cycle, then -> IDLE. busy_o is 0 from the following cycle.
- start_i while busy is ignored; there is no queueing.
- Address arithmetic wraps, e.g. w_base 0xFE -> 0xFE, 0xFF, 0x00, 0x01.
- nvec=2^CNT_W-1 is supported. The X read counter is CNT_W+2 bits.

Optional Feature:
MACROW4_SEQ_TIMEOUT_EN
- Defined: a watchdog counter runs in DRAIN and resets on every mac_valid_i. When it reaches TIMEOUT without a valid, err_o=1 (sticky) and the FSM goes to DONE.
- Not defined: DRAIN waits indefinitely, the counter is not built, and err_o is tied to 0.

Test Plan:
- Reset/idle: assert reset_n=0 mid-cycle -> all outputs 0 immediately and busy_o=0. Release -> outputs stay 0 with start_i=0.
- Weight load, nvec=2: mem[0x10..0x13]=16'h8055, w_base=0x10, x_base=0x20, mem[0x20..0x23]=16'h3155, mem[0x24..0x27]=16'h6473.
  - Required: mem_addr_o 0x10..0x13 then 0x20..0x27 on t1..t12.
  - enW_o 0001/0010/0100/1000 with W_o=16'h8055 on t3..t6.
  - enX_o=1 on t7..t14 with X_o 3155 x4 then 6473 x4.
- Result collection: model macrow4 raising mac_valid_i 5 cycles after each 4th enX with Y=16'hAAAA then 16'hBBBB.
  - Required: y_valid_o the next cycle with y_idx_o 0 then 1 and matching y_o.
  - done_o one cycle after the second result; busy_o low the cycle after that.
- Boundaries:
  - nvec=0 -> done_o at t1, no mem_rd_o.
  - w_base=0xFE -> addresses FE, FF, 00, 01.
  - start_i pulsed during STREAMX -> ignored, sequence unchanged.
- Reset mid-STREAMX (reset_n low at t9):
  - Outputs clear asynchronously.
  - A new start after release produces the full correct sequence from t1.
- With MACROW4_SEQ_TIMEOUT_EN, TIMEOUT=64, nvec=1, no mac_valid_i:
  - err_o=1 and done_o exactly 64 cycles after entering DRAIN.
  - err_o clears on the next accepted start.

Source files
------------

// File: rtl/macrow4_seq.sv
// macrow4 FP16 MAC-row sequencer: loads 4 weights, streams 4*nvec X elements and forwards results; enW/enX lag reads by 2 cycles.
// All outputs registered, no backpressure; MACROW4_SEQ_TIMEOUT_EN adds a DRAIN watchdog driving err_o.
module macrow4_seq #(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [CNT_W-1:0]  nvec_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [3:0]        enW_o,
  output logic [15:0]       W_o,
  output logic              enX_o,
  output logic [15:0]       X_o,
  input  logic              mac_valid_i,
  input  logic [15:0]       mac_y_i,
  output logic              y_valid_o,
  output logic [15:0]       y_o,
  output logic [CNT_W-1:0]  y_idx_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOADW, S_STREAMX, S_DRAIN, S_DONE} state_t;
  localparam int XC_W = CNT_W + 2;

  state_t            r_state, w_state_nxt;
  logic [XC_W-1:0]   r_cnt, w_cnt_nxt, w_xlast;
  logic              r_mem_rd, w_rd_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt, r_x_base;
  logic [CNT_W-1:0]  r_nvec, r_res_cnt, r_y_idx;
  logic              r_busy, r_done, w_start_acc, w_fwd, w_drain_ok, w_wd_expire;
  logic              r_p1_vld, r_p1_isx;
  logic [1:0]        r_p1_widx;
  logic [3:0]        r_enw;
  logic [15:0]       r_w, r_x, r_y;
  logic              r_enx, r_y_vld;

  assign w_xlast    = {r_nvec, 2'b00} - XC_W'(1);
  // The pipeline stage empty means the final enX is already on the outputs
  assign w_drain_ok = !r_p1_vld && (r_res_cnt == r_nvec);
  assign w_fwd      = mac_valid_i && (r_res_cnt < r_nvec) &&
                      ((r_state == S_LOADW) || (r_state == S_STREAMX) || (r_state == S_DRAIN));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_start_acc = 1'b1;
          if (nvec_i == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOADW;
            w_rd_nxt    = 1'b1;
            w_addr_nxt  = w_base_i;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_LOADW: begin
        w_rd_nxt = 1'b1;
        if (r_cnt[1:0] == 2'd3) begin
          w_state_nxt = S_STREAMX;
          w_addr_nxt  = r_x_base;
          w_cnt_nxt   = '0;
        end else begin
          w_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_cnt_nxt  = r_cnt + XC_W'(1);
        end
      end
      S_STREAMX: begin
        if (r_cnt == w_xlast) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = r_mem_addr + ADDR_W'(1);
          w_cnt_nxt  = r_cnt + XC_W'(1);
        end
      end
      S_DRAIN: begin
        if (w_drain_ok || w_wd_expire) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_x_base   <= '0;
      r_nvec     <= '0;
      r_res_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_p1_vld   <= 1'b0;
      r_p1_isx   <= 1'b0;
      r_p1_widx  <= '0;
      r_enw      <= '0;
      r_w        <= '0;
      r_enx      <= 1'b0;
      r_x        <= '0;
      r_y_vld    <= 1'b0;
      r_y        <= '0;
      r_y_idx    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_rd   <= w_rd_nxt;
      r_mem_addr <= w_addr_nxt;
      if (w_start_acc) begin
        r_x_base <= x_base_i;
        r_nvec   <= nvec_i;
      end
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      // Tag each read with its destination; data lands next cycle and is driven the one after
      r_p1_vld  <= r_mem_rd;
      r_p1_isx  <= (r_state == S_STREAMX);
      r_p1_widx <= r_cnt[1:0];
      r_enw     <= '0;
      r_enx     <= 1'b0;
      if (r_p1_vld) begin
        if (r_p1_isx) begin
          r_enx <= 1'b1;
          r_x   <= mem_rdata_i;
        end else begin
          r_enw <= 4'b0001 << r_p1_widx;
          r_w   <= mem_rdata_i;
        end
      end
      r_y_vld <= w_fwd;
      if (w_fwd) begin
        r_y     <= mac_y_i;
        r_y_idx <= r_res_cnt;
      end
      if (w_start_acc) r_res_cnt <= '0;
      else if (w_fwd) r_res_cnt <= r_res_cnt + CNT_W'(1);
    end
  end

`ifdef MACROW4_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_err;

  assign w_wd_expire = (r_state == S_DRAIN) && !w_drain_ok && !mac_valid_i &&
                       (r_wd == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state != S_DRAIN) || mac_valid_i) r_wd <= '0;
      else if (!w_wd_expire) r_wd <= r_wd + WD_W'(1);
      if (w_start_acc) r_err <= 1'b0;
      else if (w_wd_expire) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_wd_expire = 1'b0;
  // Constant 0: without the watchdog TIMEOUT has no effect
  assign err_o       = (TIMEOUT < 0);
`endif

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign mem_rd_o   = r_mem_rd;
  assign mem_addr_o = r_mem_addr;
  assign enW_o      = r_enw;
  assign W_o        = r_w;
  assign enX_o      = r_enx;
  assign X_o        = r_x;
  assign y_valid_o  = r_y_vld;
  assign y_o        = r_y;
  assign y_idx_o    = r_y_idx;

endmodule

// File: tb/tb_macrow4_seq.sv
// Scoreboard bench for macrow4_seq: expected reads, enW/enX, results and done are queued per command with their cycle.
module tb_macrow4_seq;

  logic        clk = 1'b0;
  logic        reset_n, start_i;
  logic [7:0]  w_base_i, x_base_i, nvec_i;
  logic        busy_o, done_o, err_o, mem_rd_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_rdata_i;
  logic [3:0]  enW_o;
  logic [15:0] W_o, X_o, mac_y_i, y_o;
  logic        enX_o, mac_valid_i, y_valid_o;
  logic [7:0]  y_idx_o;

  macrow4_seq #(.ADDR_W(8), .CNT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .w_base_i(w_base_i),
    .x_base_i(x_base_i), .nvec_i(nvec_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .enW_o(enW_o), .W_o(W_o), .enX_o(enX_o), .X_o(X_o),
    .mac_valid_i(mac_valid_i), .mac_y_i(mac_y_i), .y_valid_o(y_valid_o),
    .y_o(y_o), .y_idx_o(y_idx_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] v;} ev_t;
  ev_t rdq[$], wq[$], xq[$], yq[$], dq[$], sched[$];
  int  nchk = 0, nerr = 0;
  int  t0 = 0, model_idx = 0, model_n = 0, xcnt = 0, extra_cyc = -1;
  bit  started = 0, mac_en = 1, in_reset = 0, done_seen = 0;

  logic [15:0] mem [256];
  logic [15:0] mem_q = '0;
  always @(posedge clk) if (mem_rd_o) mem_q <= mem[mem_addr_o];
  assign mem_rdata_i = mem_q;

  function automatic void check(string nm, int gc, logic [31:0] gv, int ec, logic [31:0] ev);
    nchk++;
    if (gc != ec || gv !== ev) begin
      nerr++;
      $display("FAIL %s: got cyc %0d val %h, expected cyc %0d val %h", nm, gc - t0, gv, ec - t0, ev);
    end
  endfunction

  function automatic void check_v(string nm, logic [31:0] g, logic [31:0] e);
    nchk++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, g, e);
    end
  endfunction

  function automatic void unexpected(string nm, logic [31:0] gv);
    nchk++;
    nerr++;
    $display("FAIL %s: unexpected event at cyc %0d val %h, expected none", nm, cyc - t0, gv);
  endfunction

  function automatic void check_zero(string nm);
    nchk++;
    if ({busy_o, done_o, err_o, mem_rd_o, mem_addr_o, enW_o, W_o, enX_o, X_o,
         y_valid_o, y_o, y_idx_o} !== '0) begin
      nerr++;
      $display("FAIL %s: outputs busy=%b done=%b err=%b rd=%b addr=%h enW=%b W=%h enX=%b X=%h yv=%b y=%h idx=%h, expected all 0",
               nm, busy_o, done_o, err_o, mem_rd_o, mem_addr_o, enW_o, W_o, enX_o, X_o, y_valid_o, y_o, y_idx_o);
    end
  endfunction

  // Monitor: every presented DUT event is matched against the head of its queue
  always @(negedge clk) begin
    ev_t e;
    if (reset_n && !in_reset) begin
      if (mem_rd_o) begin
        if (rdq.size() == 0) unexpected("mem_rd", 32'(mem_addr_o));
        else begin e = rdq.pop_front(); check("mem_rd", cyc, 32'(mem_addr_o), e.cyc, e.v); end
      end
      if (enW_o != 4'b0) begin
        if (wq.size() == 0) unexpected("enW", 32'({enW_o, W_o}));
        else begin e = wq.pop_front(); check("enW", cyc, 32'({enW_o, W_o}), e.cyc, e.v); end
      end
      if (enX_o) begin
        if (xq.size() == 0) unexpected("enX", 32'(X_o));
        else begin e = xq.pop_front(); check("enX", cyc, 32'(X_o), e.cyc, e.v); end
      end
      if (y_valid_o) begin
        if (yq.size() == 0) unexpected("y", 32'({y_idx_o, y_o}));
        else begin e = yq.pop_front(); check("y", cyc, 32'({y_idx_o, y_o}), e.cyc, e.v); end
      end
      if (done_o) begin
        done_seen = 1;
        if (dq.size() == 0) unexpected("done", 32'(1));
        else begin e = dq.pop_front(); check("done", cyc, 32'(1), e.cyc, e.v); end
      end
    end
  end

  // macrow4 stand-in: one result 5 cycles after every 4th X element
  always @(negedge clk) begin
    if (reset_n && !in_reset && mac_en && enX_o) begin
      xcnt++;
      if (xcnt % 4 == 0) sched.push_back('{cyc + 5, $urandom});
    end
  end

  task automatic raise(input logic [15:0] y);
    int d;
    mac_valid_i = 1'b1;
    mac_y_i     = y;
    if (started && model_idx < model_n) begin
      yq.push_back('{cyc + 1, 32'({8'(model_idx), y})});
      model_idx++;
      if (model_idx == model_n) begin
        d = cyc + 2;
        if (d < t0 + 7 + 4 * model_n) d = t0 + 7 + 4 * model_n;
        dq.push_back('{d, 32'(1)});
      end
    end
  endtask

  always @(posedge clk) begin
    ev_t s;
    #1;
    mac_valid_i = 1'b0;
    mac_y_i     = 16'($urandom);
    if (sched.size() != 0 && sched[0].cyc == cyc) begin
      s = sched.pop_front();
      raise(s.v[15:0]);
    end else if (cyc == extra_cyc) begin
      raise(16'($urandom));
    end
  end

  task automatic start_cmd(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] n);
    logic [7:0] a;
    @(negedge clk);
    t0 = cyc; start_i = 1'b1; w_base_i = wb; x_base_i = xb; nvec_i = n;
    started = 1; model_idx = 0; model_n = int'(n); xcnt = 0; done_seen = 0;
    if (n == 0) dq.push_back('{t0 + 1, 32'(1)});
    else begin
      for (int k = 0; k < 4; k++) begin
        a = wb + 8'(k);
        rdq.push_back('{t0 + 1 + k, 32'(a)});
        wq.push_back('{t0 + 3 + k, 32'({4'(1 << k), mem[a]})});
      end
      for (int j = 0; j < 4 * int'(n); j++) begin
        a = xb + 8'(j);
        rdq.push_back('{t0 + 5 + j, 32'(a)});
        xq.push_back('{t0 + 7 + j, 32'(mem[a])});
      end
    end
    @(negedge clk);
    #1;
    start_i = 1'b0; w_base_i = 8'($urandom); x_base_i = 8'($urandom); nvec_i = 8'($urandom);
    check_v("busy_t1", 32'(busy_o), 32'(1));
    check_v("err_t1", 32'(err_o), 32'(0));
  endtask

  task automatic finish_run(input bit exp_err);
    int n_wait = 0;
    while (!done_seen && n_wait < 3000) begin
      @(negedge clk);
      #1;
      n_wait++;
    end
    if (!done_seen) unexpected("done_timeout", 32'(n_wait));
    check_v("err_at_done", 32'(err_o), 32'(exp_err));
    @(negedge clk);
    #1;
    check_v("busy_after_done", 32'(busy_o), 32'(0));
    check_v("queues_empty", 32'(rdq.size() + wq.size() + xq.size() + yq.size() + dq.size() + sched.size()), 32'(0));
    started = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset_n = 1'b0; start_i = 1'b0; w_base_i = '0; x_base_i = '0; nvec_i = '0;
    mac_valid_i = 1'b0; mac_y_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    #1;
    check_zero("reset_outputs");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("idle_after_release");

    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 16'h8055;
      mem[8'h20 + i] = 16'h3155;
      mem[8'h24 + i] = 16'h6473;
    end
    start_cmd(8'h10, 8'h20, 8'd2);
    extra_cyc = t0 + 12 + 8;
    finish_run(1'b0);

    extra_cyc = cyc + 2;
    repeat (4) @(negedge clk);

    start_cmd(8'h33, 8'h44, 8'd0);
    finish_run(1'b0);

    start_cmd(8'hFE, 8'hFC, 8'd1);
    finish_run(1'b0);

    start_cmd(8'h80, 8'h90, 8'd3);
    while (cyc < t0 + 7) @(negedge clk);
    #1;
    start_i = 1'b1; nvec_i = 8'd0; w_base_i = 8'h00;
    @(negedge clk);
    #1;
    start_i = 1'b0;
    finish_run(1'b0);

    for (int r = 0; r < 5; r++) begin
      start_cmd(8'($urandom), 8'($urandom), 8'($urandom_range(1, 5)));
      finish_run(1'b0);
    end

    start_cmd(8'h30, 8'h40, 8'd3);
    while (cyc < t0 + 9) @(negedge clk);
    #2;
    in_reset = 1;
    reset_n  = 1'b0;
    #1;
    check_zero("reset_mid_stream");
    rdq.delete(); wq.delete(); xq.delete(); yq.delete(); dq.delete(); sched.delete();
    started = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    in_reset = 0;
    check_zero("idle_after_mid_reset");
    start_cmd(8'h30, 8'h40, 8'd3);
    finish_run(1'b0);

`ifdef MACROW4_SEQ_TIMEOUT_EN
    mac_en = 0;
    start_cmd(8'h50, 8'h60, 8'd1);
    dq.push_back('{t0 + 5 + 4 + 64, 32'(1)});
    finish_run(1'b1);
    mac_en = 1;
    start_cmd(8'h50, 8'h60, 8'd1);
    finish_run(1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
